ifetch_bridge: RTL and testbench

- Sits directly downstream of the fetch stage. It turns the fetch stage's level-held request (ice, iaddr) into an SRAM-like instruction bus transaction (req/addr_ok/data_ok).
- Returns the fetched word with if_data_ok to the fetch stage and the IF/ID register.
- Owns cancellation of in-flight fetches on pipeline flush, so that a stale instruction is never delivered after an exception redirect.

---
 rtl/ifetch_bridge_pkg.sv | 18 +
 rtl/ifetch_bridge.sv | 114 +++++++++++
 tb/tb_ifetch_bridge.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/ifetch_bridge_pkg.sv
// Shared definitions for the instruction-fetch bridge: FSM encodings, bus widths
// and pipeline control constants.
package ifetch_bridge_pkg;

   localparam int STALL_BUS     = 4;
   localparam int INST_ADDR_BUS = 32;
   localparam int INST_BUS      = 32;

   localparam logic [2:0] IF_IDLE  = 3'd0;
   localparam logic [2:0] IF_ADDR  = 3'd1;
   localparam logic [2:0] IF_DATA  = 3'd2;
   localparam logic [2:0] IF_HOLD  = 3'd3;
   localparam logic [2:0] IF_DRAIN = 3'd4;

   localparam logic        NOSTOP    = 1'b0;
   localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

endpackage

// File: rtl/ifetch_bridge.sv
// Converts the fetch stage's level-held request into one SRAM-like bus transaction
// at a time, and cancels in-flight fetches on a pipeline flush.
module ifetch_bridge
   import ifetch_bridge_pkg::*;
#(
   parameter int ADDR_W  = INST_ADDR_BUS,
   parameter int DATA_W  = INST_BUS,
   parameter int STALL_W = STALL_BUS
) (
   input  logic               cpu_clk_50M,
   input  logic               cpu_rst_n,
   input  logic               ice,
   input  logic [ADDR_W-1:0]  iaddr,
   input  logic               flush,
   input  logic [STALL_W-1:0] stall,
   output logic               if_data_ok,
   output logic [DATA_W-1:0]  inst,
   output logic               inst_req,
   output logic [ADDR_W-1:0]  inst_addr,
   input  logic               inst_addr_ok,
   input  logic               inst_data_ok,
   input  logic [DATA_W-1:0]  inst_rdata,
   output logic [2:0]         dbg_state_o
);

   logic [2:0]        state_q,  state_d;
   logic              cancel_q, cancel_d;
   logic [ADDR_W-1:0] addr_q,   addr_d;
   logic [DATA_W-1:0] inst_q,   inst_d;
   logic              valid_q,  valid_d;

   logic unused_stall_bits;
   assign unused_stall_bits = ^stall[STALL_W-1:1];

   always_comb begin
      state_d  = state_q;
      cancel_d = cancel_q;
      addr_d   = addr_q;
      inst_d   = inst_q;
      valid_d  = valid_q;
      case (state_q)
         IF_IDLE: begin
            if (ice && !flush) begin
               addr_d  = iaddr;
               state_d = IF_ADDR;
            end
         end
         // The request is never withdrawn before addr_ok; a flush seen while
         // waiting is remembered in cancel so the response gets drained.
         IF_ADDR: begin
            if (inst_addr_ok) begin
               state_d  = (flush || cancel_q) ? IF_DRAIN : IF_DATA;
               cancel_d = 1'b0;
            end else if (flush) begin
               cancel_d = 1'b1;
            end
         end
         IF_DATA: begin
            if (inst_data_ok) begin
               if (flush) begin
                  state_d = IF_IDLE;
               end else begin
                  inst_d  = inst_rdata;
                  valid_d = 1'b1;
                  state_d = IF_HOLD;
               end
            end else if (flush) begin
               state_d = IF_DRAIN;
            end
         end
         IF_HOLD: begin
            if (flush || (stall[0] == NOSTOP)) begin
               inst_d  = '0;
               valid_d = 1'b0;
               state_d = IF_IDLE;
            end
         end
         IF_DRAIN: begin
            if (inst_data_ok) begin
               state_d = IF_IDLE;
            end
         end
         default: begin
            state_d  = IF_IDLE;
            cancel_d = 1'b0;
            inst_d   = '0;
            valid_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
      if (!cpu_rst_n) begin
         state_q  <= IF_IDLE;
         cancel_q <= 1'b0;
         addr_q   <= '0;
         inst_q   <= '0;
         valid_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         cancel_q <= cancel_d;
         addr_q   <= addr_d;
         inst_q   <= inst_d;
         valid_q  <= valid_d;
      end
   end

   assign inst_req    = (state_q == IF_ADDR);
   assign inst_addr   = addr_q;
   assign inst        = inst_q;
   assign if_data_ok  = valid_q;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_ifetch_bridge.sv
// Directed bench for ifetch_bridge: linear stimulus, expected words queued when
// the bus returns data and checked when if_data_ok rises.
module tb_ifetch_bridge;
   import ifetch_bridge_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        ice;
   logic [31:0] iaddr;
   logic        flush;
   logic [3:0]  stall;
   logic        if_data_ok;
   logic [31:0] inst;
   logic        inst_req;
   logic [31:0] inst_addr;
   logic        addr_ok;
   logic        data_ok;
   logic [31:0] rdata;
   logic [2:0]  dbg_state;

   int n_assert = 0;
   int n_fail   = 0;
   logic [31:0] exp_q[$];
   logic        prev_valid = 1'b0;

   ifetch_bridge dut (
      .cpu_clk_50M (clk),
      .cpu_rst_n   (rst_n),
      .ice         (ice),
      .iaddr       (iaddr),
      .flush       (flush),
      .stall       (stall),
      .if_data_ok  (if_data_ok),
      .inst        (inst),
      .inst_req    (inst_req),
      .inst_addr   (inst_addr),
      .inst_addr_ok(addr_ok),
      .inst_data_ok(data_ok),
      .inst_rdata  (rdata),
      .dbg_state_o (dbg_state)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard: each rising if_data_ok must match the oldest queued word;
   // inst must read as NOP whenever if_data_ok is low.
   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         if (if_data_ok === 1'b1 && prev_valid === 1'b0) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_delivery", inst, 32'hxxxx_xxxx);
            end else begin
               chk("delivered_word", inst, exp_q.pop_front());
            end
         end
         if (if_data_ok !== 1'b1) chk("nop_when_invalid", inst, ZERO_WORD);
      end
      prev_valid = if_data_ok;
   end

   initial begin
      rst_n = 1'b0; ice = 1'b0; iaddr = '0; flush = 1'b0; stall = '0;
      addr_ok = 1'b0; data_ok = 1'b0; rdata = '0;
      tick(); tick();
      chk("reset_req",   {31'd0, inst_req},   32'd0);
      chk("reset_addr",  inst_addr,           32'd0);
      chk("reset_valid", {31'd0, if_data_ok}, 32'd0);
      chk("reset_inst",  inst,                ZERO_WORD);
      chk("reset_state", {29'd0, dbg_state},  {29'd0, IF_IDLE});

      // Zero-wait fetch: req at cycle 1, capture at 2, if_data_ok at 3.
      ice = 1'b1; iaddr = 32'hBFC0_0000; addr_ok = 1'b1;
      rst_n = 1'b1;
      tick();
      chk("c1_req",  {31'd0, inst_req}, 32'd1);
      chk("c1_addr", inst_addr, 32'hBFC0_0000);
      tick();
      chk("c2_req_low", {31'd0, inst_req}, 32'd0);
      data_ok = 1'b1; rdata = 32'h2408_0001; exp_q.push_back(rdata);
      tick();
      chk("c3_valid", {31'd0, if_data_ok}, 32'd1);
      chk("c3_inst",  inst, 32'h2408_0001);
      ice = 1'b0; data_ok = 1'b0;
      tick();
      chk("c4_valid", {31'd0, if_data_ok}, 32'd0);
      chk("c4_state", {29'd0, dbg_state}, {29'd0, IF_IDLE});

      // addr_ok held off for 5 cycles; address must not follow iaddr.
      ice = 1'b1; iaddr = 32'hBFC0_0000; addr_ok = 1'b0;
      tick();
      for (int i = 0; i < 5; i++) begin
         chk("wait_req",  {31'd0, inst_req}, 32'd1);
         chk("wait_addr", inst_addr, 32'hBFC0_0000);
         if (i == 1) iaddr = 32'h0000_0010;
         tick();
      end
      addr_ok = 1'b1;
      tick();
      chk("wait_data_state", {29'd0, dbg_state}, {29'd0, IF_DATA});
      data_ok = 1'b1; rdata = 32'h1111_2222; stall = 4'b0001; exp_q.push_back(rdata);
      tick();
      ice = 1'b0; data_ok = 1'b0;

      // Downstream stall keeps the word stable in HOLD.
      for (int i = 0; i < 4; i++) begin
         chk("hold_valid", {31'd0, if_data_ok}, 32'd1);
         chk("hold_inst",  inst, 32'h1111_2222);
         if (i < 3) tick();
      end
      stall = 4'b0000;
      tick();
      chk("release_valid", {31'd0, if_data_ok}, 32'd0);
      chk("release_inst",  inst, ZERO_WORD);

      // Flush in DATA without data -> DRAIN, stale data dropped.
      ice = 1'b1; iaddr = 32'h0000_0100; addr_ok = 1'b1;
      tick(); tick();
      flush = 1'b1;
      tick();
      chk("flush_data_drain", {29'd0, dbg_state}, {29'd0, IF_DRAIN});
      flush = 1'b0; iaddr = 32'hBFC0_0380; addr_ok = 1'b0;
      data_ok = 1'b1; rdata = 32'hDEAD_BEEF;
      tick();
      chk("drain_idle", {29'd0, dbg_state}, {29'd0, IF_IDLE});
      data_ok = 1'b0; addr_ok = 1'b1;
      tick();
      chk("redirect_addr", inst_addr, 32'hBFC0_0380);
      tick();
      data_ok = 1'b1; rdata = 32'h3C1A_8000; exp_q.push_back(rdata);
      tick();
      chk("redirect_valid", {31'd0, if_data_ok}, 32'd1);
      ice = 1'b0; data_ok = 1'b0;
      tick();

      // Flush coincident with data_ok in DATA -> straight to IDLE.
      ice = 1'b1; iaddr = 32'h0000_0200; addr_ok = 1'b1;
      tick(); tick();
      flush = 1'b1; data_ok = 1'b1; rdata = 32'hDEAD_BEEF;
      tick();
      chk("flush_dok_idle", {29'd0, dbg_state}, {29'd0, IF_IDLE});
      data_ok = 1'b0;
      tick();
      chk("idle_flush_no_req", {31'd0, inst_req}, 32'd0);
      flush = 1'b0;
      tick();
      ice = 1'b0;
      tick(); tick();
      data_ok = 1'b1; rdata = 32'h5555_AAAA; exp_q.push_back(rdata);
      tick();
      data_ok = 1'b0;
      tick();

      // Flush in ADDR before addr_ok: request held, then drained.
      ice = 1'b1; iaddr = 32'h0000_0300; addr_ok = 1'b0;
      tick();
      flush = 1'b1;
      tick();
      chk("cancel_req",  {31'd0, inst_req}, 32'd1);
      chk("cancel_addr", inst_addr, 32'h0000_0300);
      flush = 1'b0; iaddr = 32'hBFC0_0380;
      tick();
      chk("cancel_req_hold", {31'd0, inst_req}, 32'd1);
      addr_ok = 1'b1;
      tick();
      chk("cancel_drain", {29'd0, dbg_state}, {29'd0, IF_DRAIN});
      addr_ok = 1'b0; data_ok = 1'b1; rdata = 32'hDEAD_BEEF;
      tick();
      chk("cancel_idle", {29'd0, dbg_state}, {29'd0, IF_IDLE});
      data_ok = 1'b0; addr_ok = 1'b1;
      tick();
      chk("cancel_new_addr", inst_addr, 32'hBFC0_0380);
      tick();
      data_ok = 1'b1; rdata = 32'h4080_6000; exp_q.push_back(rdata);
      tick();
      ice = 1'b0; data_ok = 1'b0;
      tick();

      // Async reset mid-DATA: outputs clear without a clock edge.
      ice = 1'b1; iaddr = 32'h0000_0400; addr_ok = 1'b1;
      tick(); tick();
      #2 rst_n = 1'b0;
      #1;
      chk("areset_addr",  inst_addr, 32'd0);
      chk("areset_req",   {31'd0, inst_req}, 32'd0);
      chk("areset_state", {29'd0, dbg_state}, {29'd0, IF_IDLE});
      ice = 1'b0;
      tick();
      rst_n = 1'b1; data_ok = 1'b1; rdata = 32'hDEAD_BEEF;
      tick(); tick();
      chk("late_dok_valid", {31'd0, if_data_ok}, 32'd0);
      data_ok = 1'b0;
      tick();

      chk("queue_empty", exp_q.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
